// File: rtl/block_data_memory_if.sv
// Request/response bundle between a requester (CPU or cache) and block_data_memory.
// The requester holds read or write until busywait falls.
interface block_data_memory_if #(
    parameter int ADDR_WIDTH  = 6,
    parameter int BLOCK_BYTES = 4
) ();
    logic                       read;
    logic                       write;
    logic [ADDR_WIDTH-1:0]      address;
    logic [8*BLOCK_BYTES-1:0]   writedata;
    logic [BLOCK_BYTES-1:0]     byteenable;
    logic [8*BLOCK_BYTES-1:0]   readdata;
    logic                       busywait;
    logic                       error;

    modport master (
        output read, write, address, writedata, byteenable,
        input  readdata, busywait, error
    );

    modport slave (
        input  read, write, address, writedata, byteenable,
        output readdata, busywait, error
    );
endinterface

// File: rtl/block_data_memory.sv
// Block-organised data memory with programmable access latency, byte-masked writes
// and a post-reset clear sweep, served over the read/write/busywait handshake.
module block_data_memory #(
    parameter int ADDR_WIDTH  = 6,
    parameter int BLOCK_BYTES = 4,
    parameter int LATENCY     = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    block_data_memory_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int BW    = 8*BLOCK_BYTES;
    localparam logic [7:0] COUNT_START = 8'(LATENCY - 1);

    typedef enum logic [1:0] {INIT, IDLE, BUSY, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep_index;
    logic                    op_write;
    logic [ADDR_WIDTH-1:0]   op_address;
    logic [BW-1:0]           op_data;
    logic [BLOCK_BYTES-1:0]  op_enable;
    logic [7:0]              count;
    logic [BW-1:0]           readdata_q;
    logic                    error_q;
    logic                    busywait_c;
    logic [BW-1:0]           mem [DEPTH];

    // Requests are latched on acceptance so the requester's inputs are don't-care while BUSY.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            sweep_index <= '0;
            op_write    <= 1'b0;
            op_address  <= '0;
            op_data     <= '0;
            op_enable   <= '0;
            count       <= 8'd0;
            readdata_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            error_q <= 1'b0;
            unique case (state)
                INIT: begin
                    sweep_index <= sweep_index + ADDR_WIDTH'(1);
                    if (sweep_index == {ADDR_WIDTH{1'b1}})
                        state <= IDLE;
                end
                IDLE: begin
                    if (bus.read ^ bus.write) begin
                        op_write   <= bus.write;
                        op_address <= bus.address;
                        op_data    <= bus.writedata;
                        op_enable  <= bus.byteenable;
                        count      <= COUNT_START;
                        state      <= BUSY;
                    end else if (bus.read & bus.write) begin
                        error_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (count == 8'd0) begin
                        if (!op_write)
                            readdata_q <= mem[op_address];
                        state <= DONE;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

    // An aborted write never lands because reset forces the state away from BUSY.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[sweep_index] <= '0;
        end else if (state == BUSY && count == 8'd0 && op_write) begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (op_enable[k])
                    mem[op_address][8*k +: 8] <= op_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        busywait_c = 1'b1;
        unique case (state)
            IDLE:    busywait_c = bus.read ^ bus.write;
            DONE:    busywait_c = 1'b0;
            default: busywait_c = 1'b1;
        endcase
    end

    assign bus.busywait = busywait_c;
    assign bus.readdata = readdata_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_block_data_memory.sv
// Bench for block_data_memory: instance A uses default geometry, instance B a
// 16x64-bit single-cycle variant; both share clock and reset.
module tb_block_data_memory;
    localparam int LAT_A   = 5;
    localparam int LAT_B   = 1;
    localparam int DEPTH_A = 64;
    localparam int DEPTH_B = 16;
    localparam int BOUND   = 300;

    logic clock;
    logic reset;

    block_data_memory_if #(.ADDR_WIDTH(6), .BLOCK_BYTES(4)) bus_a ();
    block_data_memory_if #(.ADDR_WIDTH(4), .BLOCK_BYTES(8)) bus_b ();

    block_data_memory #(.ADDR_WIDTH(6), .BLOCK_BYTES(4), .LATENCY(LAT_A)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a)
    );
    block_data_memory #(.ADDR_WIDTH(4), .BLOCK_BYTES(8), .LATENCY(LAT_B)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit timed_out = 0;

    logic [31:0] model_a [DEPTH_A];
    logic [63:0] model_b [DEPTH_B];
    logic [31:0] model_rd_a;
    logic [63:0] model_rd_b;

    typedef struct {
        bit          sel;
        bit          rd;
        bit          wr;
        logic [5:0]  addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [63:0] exp_rd;
        int          exp_cycles;
        bit          exp_err;
    } vec_t;

    vec_t vecs [14];

    function automatic logic get_busy(input bit sel);
        return sel ? bus_b.busywait : bus_a.busywait;
    endfunction

    function automatic logic get_err(input bit sel);
        return sel ? bus_b.error : bus_a.error;
    endfunction

    function automatic logic [63:0] get_rd(input bit sel);
        return sel ? bus_b.readdata : {32'h0, bus_a.readdata};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr, input logic [5:0] addr,
                         input logic [63:0] data, input logic [7:0] be);
        if (sel) begin
            bus_b.read = rd; bus_b.write = wr; bus_b.address = addr[3:0];
            bus_b.writedata = data; bus_b.byteenable = be;
        end else begin
            bus_a.read = rd; bus_a.write = wr; bus_a.address = addr;
            bus_a.writedata = data[31:0]; bus_a.byteenable = be[3:0];
        end
    endtask

    // Starts in IDLE just after an edge; returns edges waited until busywait fell.
    task automatic apply_stimulus(input bit sel, input bit rd, input bit wr, input logic [5:0] addr,
                                  input logic [63:0] data, input logic [7:0] be,
                                  output int cycles, output logic [63:0] rdata,
                                  output logic err, output logic err_after);
        drive(sel, rd, wr, addr, data, be);
        cycles = 0;
        #1;
        while (get_busy(sel) && cycles < BOUND) begin
            @(posedge clock); #1;
            cycles++;
        end
        if (cycles >= BOUND) timed_out = 1;
        if (rd & wr) begin
            @(posedge clock); #1;
        end
        rdata = get_rd(sel);
        err   = get_err(sel);
        drive(sel, 1'b0, 1'b0, addr, data, be);
        @(posedge clock); #1;
        err_after = get_err(sel);
    endtask

    // Reference behaviour: one edge to accept, LATENCY edges to complete.
    task automatic model_access(input bit sel, input bit rd, input bit wr, input logic [5:0] addr,
                                input logic [63:0] data, input logic [7:0] be,
                                output logic [63:0] exp_rd, output int exp_cycles, output logic exp_err);
        exp_err    = rd & wr;
        exp_cycles = (rd ^ wr) ? (sel ? LAT_B : LAT_A) + 1 : 0;
        if (rd ^ wr) begin
            if (sel) begin
                if (wr) begin
                    for (int k = 0; k < 8; k++)
                        if (be[k]) model_b[addr[3:0]][8*k +: 8] = data[8*k +: 8];
                end else model_rd_b = model_b[addr[3:0]];
            end else begin
                if (wr) begin
                    for (int k = 0; k < 4; k++)
                        if (be[k]) model_a[addr][8*k +: 8] = data[8*k +: 8];
                end else model_rd_a = model_a[addr];
            end
        end
        exp_rd = sel ? model_rd_b : {32'h0, model_rd_a};
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH_A; i++) model_a[i] = '0;
        for (int i = 0; i < DEPTH_B; i++) model_b[i] = '0;
        model_rd_a = '0;
        model_rd_b = '0;
    endtask

    task automatic run_checked(input string name, input bit sel, input bit rd, input bit wr,
                               input logic [5:0] addr, input logic [63:0] data, input logic [7:0] be);
        int cycles, exp_cycles;
        logic [63:0] rdata, exp_rd;
        logic err, err_after, exp_err;
        model_access(sel, rd, wr, addr, data, be, exp_rd, exp_cycles, exp_err);
        apply_stimulus(sel, rd, wr, addr, data, be, cycles, rdata, err, err_after);
        check_output({name, " rdata"}, rdata, exp_rd);
        check_output({name, " cycles"}, 64'(cycles), 64'(exp_cycles));
        check_output({name, " error"}, {63'h0, err}, {63'h0, exp_err});
        check_output({name, " error_after"}, {63'h0, err_after}, 64'h0);
    endtask

    initial begin
        int n, len_a, len_b, bad_init, bad_busy;
        int cycles, exp_cycles_m;
        logic [63:0] rdata, exp_rd_m;
        logic err, err_after, exp_err_m;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'h0, 64'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 6'h0, 64'h0, 8'h0);
        #1;
        check_output("reset readdata A", get_rd(1'b0), 64'h0);
        check_output("reset busywait A", {63'h0, get_busy(1'b0)}, 64'h1);
        check_output("reset error A", {63'h0, get_err(1'b0)}, 64'h0);

        // Read held across the whole clear sweep must be served afterwards.
        drive(1'b0, 1'b1, 1'b0, 6'h0, 64'h0, 8'h0);
        drive(1'b1, 1'b1, 1'b0, 6'h0, 64'h0, 8'h0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        n = 0; len_a = 0; len_b = 0; bad_init = 0;
        while ((len_a == 0 || len_b == 0) && n < BOUND) begin
            @(posedge clock); #1;
            n++;
            if (len_a == 0) begin
                if (get_rd(1'b0) !== 64'h0) bad_init++;
                if (!get_busy(1'b0)) begin len_a = n; bus_a.read = 1'b0; end
            end
            if (len_b == 0) begin
                if (get_rd(1'b1) !== 64'h0) bad_init++;
                if (!get_busy(1'b1)) begin len_b = n; bus_b.read = 1'b0; end
            end
        end
        if (n >= BOUND) timed_out = 1;
        check_output("init+read length A", 64'(len_a), 64'(DEPTH_A + 1 + LAT_A));
        check_output("init+read length B", 64'(len_b), 64'(DEPTH_B + 1 + LAT_B));
        check_output("readdata zero during init", 64'(bad_init), 64'h0);
        @(posedge clock); #1;
        clear_model();

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 6'h3F, 64'hDEADBEEF, 8'h0F, 64'h0, 6, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 6'h3F, 64'h0, 8'h00, 64'hDEADBEEF, 6, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 6'h05, 64'h11223344, 8'h0F, 64'hDEADBEEF, 6, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 6'h05, 64'hAABBCCDD, 8'h05, 64'hDEADBEEF, 6, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'h05, 64'h0, 8'h00, 64'h11BB33DD, 6, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 6'h05, 64'h0, 8'h0F, 64'h11BB33DD, 0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'h05, 64'h0, 8'h00, 64'h11BB33DD, 6, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 6'h05, 64'hFFFFFFFF, 8'h00, 64'h11BB33DD, 6, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'h05, 64'h0, 8'h00, 64'h11BB33DD, 6, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 6'h00, 64'h0, 8'h00, 64'h0, 6, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 6'h0F, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 2, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 6'h0F, 64'h0, 8'h00, 64'h0123456789ABCDEF, 2, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 6'h00, 64'hFFFFFFFFFFFFFFFF, 8'h81, 64'h0123456789ABCDEF, 2, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 6'h00, 64'h0, 8'h00, 64'hFF000000000000FF, 2, 1'b0};

        for (int i = 0; i < 14 && !timed_out; i++) begin
            model_access(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
                         exp_rd_m, exp_cycles_m, exp_err_m);
            apply_stimulus(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
                           cycles, rdata, err, err_after);
            check_output($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
            check_output($sformatf("vec%0d cycles", i), 64'(cycles), 64'(vecs[i].exp_cycles));
            check_output($sformatf("vec%0d error", i), {63'h0, err}, {63'h0, vecs[i].exp_err});
            check_output($sformatf("vec%0d error_after", i), {63'h0, err_after}, 64'h0);
        end

        for (int i = 0; i < 200 && !timed_out; i++) begin
            bit sel, rd, wr;
            int op;
            logic [5:0] addr;
            sel  = 1'($urandom_range(0, 1));
            op   = int'($urandom_range(0, 9));
            rd   = (op <= 3) || (op == 9);
            wr   = (op >= 4);
            addr = 6'($urandom_range(0, 63));
            if (sel) addr = {2'b00, addr[3:0]};
            run_checked($sformatf("rand%0d", i), sel, rd, wr, addr,
                        {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        end

        for (int a = 0; a < DEPTH_A && !timed_out; a++)
            run_checked($sformatf("sweep%0d", a), 1'b0, 1'b1, 1'b0, 6'(a), 64'h0, 8'h0);

        // Reset two cycles into a write: the write is lost and memory is re-cleared.
        if (!timed_out) begin
            run_checked("pre-reset read", 1'b0, 1'b1, 1'b0, 6'h3F, 64'h0, 8'h0);
            drive(1'b0, 1'b0, 1'b1, 6'h02, 64'hCAFEF00D, 8'h0F);
            @(posedge clock);
            @(posedge clock); #1;
            reset = 1'b1;
            drive(1'b0, 1'b0, 1'b0, 6'h0, 64'h0, 8'h0);
            #1;
            check_output("readdata cleared by reset", get_rd(1'b0), 64'h0);
            @(posedge clock); #1 reset = 1'b0;
            n = 0; len_a = 0; bad_init = 0; bad_busy = 0;
            while (len_a == 0 && n < BOUND) begin
                @(posedge clock); #1;
                n++;
                if (get_rd(1'b0) !== 64'h0) bad_init++;
                if (!get_busy(1'b0)) len_a = n;
            end
            if (n >= BOUND) timed_out = 1;
            check_output("idle init length A", 64'(len_a), 64'(DEPTH_A));
            check_output("readdata zero in second init", 64'(bad_init), 64'h0);
            clear_model();
            run_checked("aborted write addr2", 1'b0, 1'b1, 1'b0, 6'h02, 64'h0, 8'h0);
            run_checked("B cleared addrF", 1'b1, 1'b1, 1'b0, 6'h0F, 64'h0, 8'h0);
        end

        if (timed_out) begin
            errors++;
            $display("[TB] FAIL timeout: busywait stuck high for %0d cycles, expected release", BOUND);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
